// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: points table, BCD digit
// type, game states and active-low 7-segment codes.
package score_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    PLAYING = 1'b0,
    OVER    = 1'b1
  } game_state_t;

  // Indexed directly by the 3-bit lines field; entries 0 and 5..7 add nothing.
  localparam logic [7:0][3:0] POINTS = {
    4'd0, 4'd0, 4'd0, 4'd8, 4'd5, 4'd3, 4'd1, 4'd0
  };

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_scan.sv
// Multiplexed 7-segment scanner: prescaler, scan index, leading-zero
// blanking and segment decode, with registered anode/cathode outputs.
module score_scan
  import score_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   score,
  input  logic [4*NDIGITS-1:0]   high_score,
  input  logic                   show_high,
  output logic [NDIGITS-1:0]     anodes,
  output logic [6:0]             cathodes
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NDIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NDIGITS - 1);

  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx;
  logic                 wrap;
  logic [4*NDIGITS-1:0] src;
  bcd_t                 digit;
  logic                 blank;
  logic [6:0]           seg_next;
  logic [NDIGITS-1:0]   an_next;

  // The source is only sampled at a wrap, so a show_high change never
  // disturbs the slot currently on the display.
  always_comb begin
    wrap  = (presc == P_LAST);
    src   = show_high ? high_score : score;
    digit = src[4*int'(idx) +: 4];
    blank = (idx != '0);
    for (int i = 0; i < NDIGITS; i++) begin
      if (i >= int'(idx) && src[4*i +: 4] != 4'd0) blank = 1'b0;
    end
    seg_next = blank ? SEG_BLANK : seg_decode(digit);
    an_next  = ~(NDIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      idx      <= '0;
      anodes   <= '1;
      cathodes <= SEG_BLANK;
    end else if (wrap) begin
      presc    <= '0;
      anodes   <= an_next;
      cathodes <= seg_next;
      idx      <= (idx == I_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: saturating BCD score accumulation, PLAYING/OVER state
// machine, high-score capture and a scanned 7-segment display.
module score_keeper
  import score_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lines_valid,
  input  logic [2:0]           lines,
  input  logic                 perdu,
  input  logic                 new_game,
  input  logic                 show_high,
  output logic [4*NDIGITS-1:0] score,
  output logic [4*NDIGITS-1:0] high_score,
  output logic                 game_over,
  output logic [NDIGITS-1:0]   anodes,
  output logic [6:0]           cathodes
);

  localparam logic [4*NDIGITS-1:0] ALL_NINES = {NDIGITS{4'h9}};

  game_state_t          state_q, state_d;
  logic [4*NDIGITS-1:0] score_q, score_d;
  logic [4*NDIGITS-1:0] high_q, high_d;
  logic [4*NDIGITS-1:0] sum;
  logic [3:0]           carry;
  logic [4:0]           dsum;
  logic [4:0]           dfix;

  // Ripple decimal add of a 0..8 point value; a carry out of the top digit
  // saturates the score instead of wrapping.
  always_comb begin
    sum   = score_q;
    carry = POINTS[lines];
    dsum  = '0;
    dfix  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, carry};
      dfix = dsum - 5'd10;
      if (dsum > 5'd9) begin
        sum[4*i +: 4] = dfix[3:0];
        carry         = 4'd1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        carry         = 4'd0;
      end
    end
    if (carry != 4'd0) sum = ALL_NINES;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    if (new_game) begin
      state_d = PLAYING;
      score_d = '0;
    end else if (state_q == PLAYING) begin
      if (lines_valid) score_d = sum;
      // Points from the same cycle count toward the final score.
      if (perdu) begin
        state_d = OVER;
        if (score_d > high_q) high_d = score_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PLAYING;
      score_q <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign game_over  = (state_q == OVER);

  score_scan #(
    .NDIGITS     (NDIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .score      (score_q),
    .high_score (high_q),
    .show_high  (show_high),
    .anodes     (anodes),
    .cathodes   (cathodes)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboarded bench for score_keeper: decimal reference model for score and
// high score, plus a cycle-accurate model of the digit scan.
module tb_score_keeper;

  localparam int N    = 4;
  localparam int RD   = 4;
  localparam int MAXV = 9999;
  localparam int W    = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lines_valid = 1'b0;
  logic [2:0]  lines = 3'd0;
  logic        perdu = 1'b0;
  logic        new_game = 1'b0;
  logic        show_high = 1'b0;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        game_over;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;

  always #5 clk = ~clk;

  score_keeper #(.NDIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .reset       (reset),
    .lines_valid (lines_valid),
    .lines       (lines),
    .perdu       (perdu),
    .new_game    (new_game),
    .show_high   (show_high),
    .score       (score),
    .high_score  (high_score),
    .game_over   (game_over),
    .anodes      (anodes),
    .cathodes    (cathodes)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int p_score = 0, p_high = 0;
  bit p_over = 1'b0;
  int m_score = 0, m_high = 0;
  bit m_over = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v = 0;
    for (int i = 0; i < N; i++) v += int'(b[4*i +: 4]) * pow10(i);
    return v;
  endfunction

  function automatic int pts_of(input int l);
    case (l)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Driver: called #1 after a rising edge, pulses for exactly one cycle.
  task automatic issue(input bit lv, input int ln, input bit pd, input bit ng);
    lines_valid = lv;
    lines       = 3'(ln);
    perdu       = pd;
    new_game    = ng;
    if (ng) begin
      p_score = 0;
      p_over  = 1'b0;
    end else if (!p_over) begin
      if (lv) begin
        p_score += pts_of(ln);
        if (p_score > MAXV) p_score = MAXV;
      end
      if (pd) begin
        p_over = 1'b1;
        if (p_score > p_high) p_high = p_score;
      end
    end
    exp_q.push_back({to_bcd(p_score), to_bcd(p_high), p_over});
    @(posedge clk);
    #1;
    lines_valid = 1'b0;
    lines       = 3'd0;
    perdu       = 1'b0;
    new_game    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a pulse seen at an edge has its result visible by the next negedge.
  logic resp_due = 1'b0;
  logic [W-1:0] e;
  always @(posedge clk or negedge reset) begin
    if (!reset) resp_due <= 1'b0;
    else        resp_due <= lines_valid | perdu | new_game;
  end

  always @(negedge clk) begin
    if (resp_due) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: response with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("score", 32'(score), 32'(e[32:17]));
        check("high_score", 32'(high_score), 32'(e[16:1]));
        check("game_over", 32'(game_over), 32'(e[0]));
        m_score = from_bcd(e[32:17]);
        m_high  = from_bcd(e[16:1]);
        m_over  = e[0];
      end
    end
  end

  // Display model: slot k (k>=1) starts at the k*RD-th edge after release
  // and shows digit (k-1) mod N of the value held just before that edge.
  int edge_cnt = 0;
  int dd, dv;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_cat = 7'h7F;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt = 0;
      exp_an   = 4'hF;
      exp_cat  = 7'h7F;
    end else begin
      edge_cnt++;
      if (edge_cnt % RD == 0) begin
        dd = (edge_cnt / RD - 1) % N;
        dv = show_high ? m_high : m_score;
        exp_an  = ~(4'b0001 << dd);
        exp_cat = (dd > 0 && dv < pow10(dd)) ? 7'h7F : seg_of((dv / pow10(dd)) % 10);
      end
    end
  end

  always @(negedge clk) begin
    check("anodes", 32'(anodes), 32'(exp_an));
    check("cathodes", 32'(cathodes), 32'(exp_cat));
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_score", 32'(score), 32'h0);
    check("rst_high", 32'(high_score), 32'h0);
    check("rst_game_over", 32'(game_over), 32'h0);
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_cathodes", 32'(cathodes), 32'h7F);
    reset = 1'b1;

    // Two tetrises, then a full scan of "16" with blanked upper digits.
    issue(1, 4, 0, 0);
    issue(1, 4, 0, 0);
    idle(2);
    check("score_0016", 32'(score), 32'h0016);
    idle(20);
    show_high = 1'b1;
    idle(18);
    show_high = 1'b0;
    idle(6);

    // 12 + 3 with same-cycle game over, then ignored lines in OVER.
    issue(0, 0, 0, 1);
    issue(1, 4, 0, 0);
    issue(1, 2, 0, 0);
    issue(1, 1, 0, 0);
    issue(1, 2, 1, 0);
    issue(1, 4, 0, 0);
    idle(3);
    check("high_0015", 32'(high_score), 32'h0015);
    idle(1);
    show_high = 1'b1;
    idle(17);

    // Lower final score keeps the high; new_game beats lines/perdu.
    issue(0, 0, 0, 1);
    issue(1, 4, 0, 0);
    issue(1, 1, 0, 0);
    issue(0, 0, 1, 0);
    issue(1, 3, 0, 1);
    issue(0, 0, 1, 1);
    show_high = 1'b0;
    idle(10);

    repeat (300) begin
      if ($urandom_range(0, 9) < 2) begin
        idle($urandom_range(1, 3));
      end else begin
        bit lv, pd, ng;
        lv = ($urandom_range(0, 3) != 0);
        pd = ($urandom_range(0, 15) == 0);
        ng = ($urandom_range(0, 19) == 0);
        if (!lv && !pd && !ng) lv = 1'b1;
        issue(lv, $urandom_range(0, 7), pd, ng);
      end
      if ($urandom_range(0, 15) == 0) show_high = 1'($urandom_range(0, 1));
    end
    show_high = 1'b0;
    idle(4);

    // Climb to 9995, then saturate at 9999.
    issue(0, 0, 0, 1);
    repeat (1249) issue(1, 4, 0, 0);
    issue(1, 2, 0, 0);
    idle(1);
    check("score_9995", 32'(score), 32'h9995);
    issue(1, 4, 0, 0);
    issue(1, 1, 0, 0);
    idle(1);
    check("score_sat", 32'(score), 32'h9999);
    issue(0, 0, 1, 0);
    show_high = 1'b1;
    idle(20);
    show_high = 1'b0;

    // Reach 42, then assert reset in the middle of a scan slot.
    issue(0, 0, 0, 1);
    repeat (5) issue(1, 4, 0, 0);
    issue(1, 1, 0, 0);
    issue(1, 1, 0, 0);
    idle(7);
    check("score_0042", 32'(score), 32'h0042);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_score", 32'(score), 32'h0);
    check("async_high", 32'(high_score), 32'h0);
    check("async_game_over", 32'(game_over), 32'h0);
    check("async_anodes", 32'(anodes), 32'hF);
    check("async_cathodes", 32'(cathodes), 32'h7F);
    exp_q.delete();
    p_score = 0; p_high = 0; p_over = 1'b0;
    m_score = 0; m_high = 0; m_over = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    issue(1, 3, 0, 0);
    idle(24);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter NDIGITS, 4, BCD digits of score and display (2..8).
REQ-002 Parameter REFRESH_DIV, 50000, clk cycles per digit scan slot (>=2).
REQ-003 clk  input  1  single system clock; all state rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 lines_valid  input  1  one-cycle pulse: a clear event occurred.
REQ-006 lines  input  3  rows cleared in that event (1..4; 0 or >4 ignored).
REQ-007 perdu  input  1  game-over pulse.
REQ-008 new_game  input  1  pulse: clear score, return to PLAYING.
REQ-009 show_high  input  1  level: 1 displays high score, 0 displays current score.
REQ-010 score  output  4*NDIGITS  current score, packed BCD, digit 0 in LSBs.
REQ-011 high_score  output  4*NDIGITS  best final score since reset, packed BCD.
REQ-012 game_over  output  1  high while state is OVER.
REQ-013 anodes  output  NDIGITS  active-low digit enables, one-hot-low while scanning.
REQ-014 cathodes  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-015 States PLAYING and OVER; PLAYING->OVER on perdu; any state->PLAYING on new_game.
REQ-016 Points per event: lines 1->1, 2->3, 3->5, 4->8; other values add 0.
REQ-017 In PLAYING, valid lines_valid adds points to score in BCD with decimal carry; result visible on score the next cycle.
REQ-018 Score saturates at all-9s; no wrap to zero.
REQ-019 lines_valid in OVER is ignored.
REQ-020 lines_valid and perdu in the same PLAYING cycle: points are added, then OVER is entered.
REQ-021 On entry to OVER, high_score loads the final score (including any same-cycle points) if strictly greater; updated the next cycle.
REQ-022 new_game clears score to 0 the next cycle and has priority over lines_valid and perdu in the same cycle; high_score is kept.
REQ-023 Prescaler counts 0..REFRESH_DIV-1; at wrap, scan index advances 0..NDIGITS-1 and wraps to 0.
REQ-024 anodes drive low only the bit at scan index; cathodes show that digit of the selected value (show_high).
REQ-025 Leading-zero blanking: digits above the most significant nonzero digit are blank (cathodes all 1); digit 0 is never blanked, so zero shows "0".
REQ-026 Display source switches at the next scan slot after show_high changes; no glitch within a slot.
REQ-027 Registered display outputs: anodes/cathodes change only on the cycle after a prescaler wrap.

Reset
REQ-028 While reset is low: score=0, high_score=0, state PLAYING, game_over=0, prescaler=0, scan index=0, anodes all 1, cathodes all 1.
REQ-029 Reset asserted mid-event discards any pending addition; first digit drives after the first prescaler wrap following release.

Structure
REQ-030 Shared package score_pkg holds the points table, the BCD-digit type, and the 7-segment code constants for 0-9 and blank.
REQ-031 Display scan/mux/decode (prescaler, scan index, blanking, segment decode) is one sub-module, score_scan; BCD add and state machine stay in score_keeper.

Verification (NDIGITS=4, REFRESH_DIV=4)
REQ-032 Release reset, lines=4 pulse x2 -> score 0x0016; display after full scan: digits 1,0 show "6","1", digits 3,2 blank.
REQ-033 Preload score 0x9995, lines=4 -> score 0x9999 (saturated); another lines=1 -> stays 0x9999.
REQ-034 Score 0x0012, lines=2 and perdu same cycle -> score 0x0015, game_over=1, high_score 0x0015; later lines_valid -> no change.
REQ-035 high_score 0x0015, new_game, score to 0x0009, perdu -> high_score stays 0x0015; new_game+lines_valid same cycle -> score 0x0000.
REQ-036 Scan check: anodes sequence 1110,1101,1011,0111, each held 4 cycles, repeating; show_high=1 mid-slot -> source changes at next slot.
REQ-037 Assert reset mid-scan with score 0x0042 -> all outputs at reset values asynchronously, high_score 0x0000.
